// File: rtl/register_file_sb_if.sv
// Decode/writeback side of the scoreboarded register file: read ports, writeback, issue and flush.
// Read ports are flattened; port i lives at Rs[i*AW +: AW] and RuRs[i*XLEN +: XLEN].
interface register_file_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   Rs;
    logic [NRD*XLEN-1:0] RuRs;
    logic [NRD-1:0]      RsBusy;
    logic                RuWr;
    logic [AW-1:0]       Rd;
    logic [XLEN-1:0]     RuDataWr;
    logic                IssueEn;
    logic [AW-1:0]       IssueRd;
    logic                Flush;
    logic [AW:0]         PendCnt;

    modport master (
        output Rs, RuWr, Rd, RuDataWr, IssueEn, IssueRd, Flush,
        input  RuRs, RsBusy, PendCnt
    );

    modport slave (
        input  Rs, RuWr, Rd, RuDataWr, IssueEn, IssueRd, Flush,
        output RuRs, RsBusy, PendCnt
    );
endinterface

// File: rtl/register_file_sb.sv
// Multi-read-port register file with write-to-read bypass and a per-register busy scoreboard.
// Decode issues mark destinations busy, writebacks clear them; Flush drops every pending mark.

// One combinational read lane: stored value, bypassed writeback data, or hardwired zero.
module register_file_sb_rdport #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic [AW-1:0]                rs,
    input  logic [NREG-1:0][XLEN-1:0]    regs,
    input  logic [NREG-1:0]              busy,
    input  logic                         wr_ok,
    input  logic [AW-1:0]                rd,
    input  logic [XLEN-1:0]              wdata,
    output logic [XLEN-1:0]              rdata,
    output logic                         rbusy
);
    logic zero_hit;
    logic byp_hit;

    assign zero_hit = ZERO_R0 && (rs == '0);
    assign byp_hit  = BYPASS && wr_ok && (rs == rd);

    // A forwarded write completes the producer, so the source is no longer pending
    // even if a same-cycle issue re-marks it from the next edge on.
    always_comb begin
        rdata = regs[rs];
        rbusy = busy[rs];
        if (zero_hit) begin
            rdata = '0;
            rbusy = 1'b0;
        end else if (byp_hit) begin
            rdata = wdata;
            rbusy = 1'b0;
        end
    end
endmodule

module register_file_sb #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic               Clk,
    input  logic               Rst,
    register_file_sb_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0]           busy;
    logic [NREG-1:0]           busy_nxt;
    logic [AW:0]               pend;
    logic [AW:0]               pend_nxt;
    logic                      wr_ok;
    logic                      iss_ok;
    logic [NRD-1:0][XLEN-1:0]  rdata;
    logic [NRD-1:0]            rbusy;

    // Gating with Rst keeps the bypass from leaking write data while reset holds reads at 0.
    assign wr_ok  = bus.RuWr && !Rst && !(ZERO_R0 && (bus.Rd == '0));
    assign iss_ok = bus.IssueEn && !(ZERO_R0 && (bus.IssueRd == '0));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            regs <= '0;
        end else if (wr_ok) begin
            regs[bus.Rd] <= bus.RuDataWr;
        end
    end

    // Priority: flush, then writeback clear, then issue set (a new producer wins).
    always_comb begin
        busy_nxt = busy;
        if (bus.Flush) begin
            busy_nxt = '0;
        end else begin
            if (bus.RuWr)
                busy_nxt[bus.Rd] = 1'b0;
            if (iss_ok)
                busy_nxt[bus.IssueRd] = 1'b1;
        end
    end

    always_comb begin
        pend_nxt = '0;
        for (int i = 0; i < NREG; i++)
            pend_nxt = pend_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            busy <= '0;
            pend <= '0;
        end else begin
            busy <= busy_nxt;
            pend <= pend_nxt;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        register_file_sb_rdport #(
            .XLEN    (XLEN),
            .NREG    (NREG),
            .BYPASS  (BYPASS),
            .ZERO_R0 (ZERO_R0)
        ) u_rd (
            .rs    (bus.Rs[i*AW +: AW]),
            .regs  (regs),
            .busy  (busy),
            .wr_ok (wr_ok),
            .rd    (bus.Rd),
            .wdata (bus.RuDataWr),
            .rdata (rdata[i]),
            .rbusy (rbusy[i])
        );
    end

    assign bus.RuRs    = rdata;
    assign bus.RsBusy  = rbusy;
    assign bus.PendCnt = pend;
endmodule

// File: tb/tb_register_file_sb.sv
// Directed table of vectors plus reset/no-bypass sequences and a randomized reference-model run.
module tb_register_file_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 3;
    localparam int AW   = 5;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    register_file_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus1 ();
    register_file_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus0 ();

    register_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1'b1), .ZERO_R0(1'b1))
        dut1 (.Clk(Clk), .Rst(Rst), .bus(bus1.slave));
    register_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1'b0), .ZERO_R0(1'b1))
        dut0 (.Clk(Clk), .Rst(Rst), .bus(bus0.slave));

    typedef struct packed {
        logic [2:0][AW-1:0] rs;
        logic               wr;
        logic [AW-1:0]      rd;
        logic [31:0]        wd;
        logic               ien;
        logic [AW-1:0]      ird;
        logic               fl;
        logic [2:0][31:0]   exp_d;
        logic [2:0]         exp_b;
        logic [AW:0]        exp_p;
    } vec_t;

    vec_t tbl [21];
    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [NREG];
    logic [NREG-1:0] m_busy;
    int m_pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int r0, input int r1, input int r2, input logic wr, input int rd,
                         input logic [31:0] wd, input logic ien, input int ird, input logic fl);
        bus1.Rs = {AW'(r2), AW'(r1), AW'(r0)};
        bus0.Rs = {AW'(r2), AW'(r1), AW'(r0)};
        bus1.RuWr = wr;      bus0.RuWr = wr;
        bus1.Rd = AW'(rd);   bus0.Rd = AW'(rd);
        bus1.RuDataWr = wd;  bus0.RuDataWr = wd;
        bus1.IssueEn = ien;  bus0.IssueEn = ien;
        bus1.IssueRd = AW'(ird); bus0.IssueRd = AW'(ird);
        bus1.Flush = fl;     bus0.Flush = fl;
    endtask

    function automatic vec_t mk(input int r0, input int r1, input int r2, input logic wr, input int rd,
                                input logic [31:0] wd, input logic ien, input int ird, input logic fl,
                                input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                                input logic [2:0] eb, input int ep);
        vec_t v;
        v.rs = {AW'(r2), AW'(r1), AW'(r0)};
        v.wr = wr; v.rd = AW'(rd); v.wd = wd;
        v.ien = ien; v.ird = AW'(ird); v.fl = fl;
        v.exp_d = {e2, e1, e0};
        v.exp_b = eb;
        v.exp_p = (AW+1)'(ep);
        return v;
    endfunction

    initial begin
        // rs0 rs1 rs2 | wr rd data | ien ird | fl || exp d0 d1 d2 | busy{p2,p1,p0} | PendCnt
        tbl[0]  = mk(1,2,3, 0,0,0,            0,0, 0, 0,0,0,                                3'b000, 0);
        tbl[1]  = mk(1,2,0, 1,1,32'h11111111, 0,0, 0, 32'h11111111,0,0,                     3'b000, 0);
        tbl[2]  = mk(1,2,7, 1,2,32'h22222222, 0,0, 0, 32'h11111111,32'h22222222,0,          3'b000, 0);
        tbl[3]  = mk(0,1,2, 1,0,32'h00001234, 1,0, 0, 0,32'h11111111,32'h22222222,          3'b000, 0);
        tbl[4]  = mk(0,0,0, 0,0,0,            0,0, 0, 0,0,0,                                3'b000, 0);
        tbl[5]  = mk(7,7,1, 1,7,32'hA5A5A5A5, 0,0, 0, 32'hA5A5A5A5,32'hA5A5A5A5,32'h11111111, 3'b000, 0);
        tbl[6]  = mk(3,4,7, 0,0,0,            1,3, 0, 0,0,32'hA5A5A5A5,                     3'b000, 0);
        tbl[7]  = mk(3,4,7, 0,0,0,            1,4, 0, 0,0,32'hA5A5A5A5,                     3'b001, 1);
        tbl[8]  = mk(3,4,5, 0,0,0,            0,0, 0, 0,0,0,                                3'b011, 2);
        tbl[9]  = mk(3,4,3, 1,3,32'h33333333, 0,0, 0, 32'h33333333,0,32'h33333333,          3'b010, 2);
        tbl[10] = mk(3,4,5, 1,4,32'h44444444, 1,4, 0, 32'h33333333,32'h44444444,0,          3'b000, 1);
        tbl[11] = mk(3,4,5, 0,0,0,            0,0, 0, 32'h33333333,32'h44444444,0,          3'b010, 1);
        tbl[12] = mk(5,4,5, 1,5,32'h55555555, 0,0, 0, 32'h55555555,32'h44444444,32'h55555555, 3'b010, 1);
        tbl[13] = mk(4,5,6, 1,4,32'h44440000, 0,0, 0, 32'h44440000,32'h55555555,0,          3'b000, 1);
        tbl[14] = mk(4,5,6, 0,0,0,            0,0, 0, 32'h44440000,32'h55555555,0,          3'b000, 0);
        tbl[15] = mk(1,2,3, 0,0,0,            1,1, 0, 32'h11111111,32'h22222222,32'h33333333, 3'b000, 0);
        tbl[16] = mk(1,2,3, 0,0,0,            1,2, 0, 32'h11111111,32'h22222222,32'h33333333, 3'b001, 1);
        tbl[17] = mk(1,2,3, 0,0,0,            1,3, 0, 32'h11111111,32'h22222222,32'h33333333, 3'b011, 2);
        tbl[18] = mk(1,9,8, 1,8,32'h88888888, 1,9, 1, 32'h11111111,0,32'h88888888,          3'b001, 3);
        tbl[19] = mk(1,2,3, 0,0,0,            0,0, 0, 32'h11111111,32'h22222222,32'h33333333, 3'b000, 0);
        tbl[20] = mk(9,8,0, 0,0,0,            0,0, 0, 0,32'h88888888,0,                     3'b000, 0);

        // Reset state, then an async reset landing mid-cycle with live state.
        Rst = 1'b1;
        drive(5,6,0, 0,0,0, 0,0, 0);
        #12;
        chk("reset_rdata", bus1.RuRs, '0);
        chk("reset_busy", bus1.RsBusy, '0);
        chk("reset_pend", bus1.PendCnt, '0);
        @(negedge Clk);
        Rst = 1'b0;
        drive(5,6,0, 1,5,32'hDEADBEEF, 1,6, 0);
        @(negedge Clk);
        drive(5,6,0, 0,0,0, 0,0, 0);
        #1;
        chk("pre_rst_r5", bus1.RuRs[31:0], 32'hDEADBEEF);
        chk("pre_rst_busy6", bus1.RsBusy[1], 1'b1);
        chk("pre_rst_pend", bus1.PendCnt, 6'd1);
        Rst = 1'b1;
        #1;
        chk("async_rst_r5", bus1.RuRs[31:0], 32'h0);
        chk("async_rst_busy", bus1.RsBusy, '0);
        chk("async_rst_pend", bus1.PendCnt, '0);
        #1;
        Rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            @(negedge Clk);
            drive(int'(tbl[i].rs[0]), int'(tbl[i].rs[1]), int'(tbl[i].rs[2]), tbl[i].wr, int'(tbl[i].rd),
                  tbl[i].wd, tbl[i].ien, int'(tbl[i].ird), tbl[i].fl);
            #1;
            chk($sformatf("v%0d_d0", i), bus1.RuRs[31:0],  tbl[i].exp_d[0]);
            chk($sformatf("v%0d_d1", i), bus1.RuRs[63:32], tbl[i].exp_d[1]);
            chk($sformatf("v%0d_d2", i), bus1.RuRs[95:64], tbl[i].exp_d[2]);
            chk($sformatf("v%0d_busy", i), bus1.RsBusy, tbl[i].exp_b);
            chk($sformatf("v%0d_pend", i), bus1.PendCnt, tbl[i].exp_p);
            // Non-bypassing instance sees the same stimulus: old value and raw busy until the edge.
            if (i == 5) chk("nobyp_old_r7", bus0.RuRs[31:0], 32'h0);
            if (i == 6) chk("nobyp_new_r7", bus0.RuRs[95:64], 32'hA5A5A5A5);
            if (i == 9) chk("nobyp_busy_r3", bus0.RsBusy[0], 1'b1);
            if (i == 9) chk("nobyp_old_r3", bus0.RuRs[31:0], 32'h0);
        end

        // Randomized run against a reference model, starting from a fresh reset.
        @(negedge Clk);
        drive(0,0,0, 0,0,0, 0,0, 0);
        Rst = 1'b1;
        #1;
        Rst = 1'b0;
        for (int r = 0; r < NREG; r++) m_regs[r] = '0;
        m_busy = '0;
        m_pend = 0;
        for (int c = 0; c < 10000; c++) begin
            int rs [3];
            logic wr, ien, fl;
            int rd, ird;
            logic [31:0] wd;
            logic [2:0] eb;
            @(negedge Clk);
            for (int p = 0; p < 3; p++) rs[p] = int'($urandom_range(0, NREG-1));
            wr  = ($urandom_range(0, 1) == 1);
            rd  = int'($urandom_range(0, NREG-1));
            wd  = $urandom;
            ien = ($urandom_range(0, 9) < 3);
            ird = int'($urandom_range(0, NREG-1));
            fl  = ($urandom_range(0, 99) < 3);
            drive(rs[0], rs[1], rs[2], wr, rd, wd, ien, ird, fl);
            #1;
            for (int p = 0; p < 3; p++) begin
                logic [31:0] ed;
                if (rs[p] == 0) begin
                    ed = '0; eb[p] = 1'b0;
                end else if (wr && rd == rs[p]) begin
                    ed = wd; eb[p] = 1'b0;
                end else begin
                    ed = m_regs[rs[p]]; eb[p] = m_busy[rs[p]];
                end
                chk($sformatf("rnd%0d_d%0d", c, p), bus1.RuRs[p*32 +: 32], ed);
            end
            chk($sformatf("rnd%0d_busy", c), bus1.RsBusy, eb);
            chk($sformatf("rnd%0d_pend", c), bus1.PendCnt, 64'(m_pend));
            if (wr && rd != 0) m_regs[rd] = wd;
            if (fl) m_busy = '0;
            else begin
                if (wr) m_busy[rd] = 1'b0;
                if (ien && ird != 0) m_busy[ird] = 1'b1;
            end
            m_pend = $countones(m_busy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
